membus_arbiter: RTL and testbench

- Shares one single-port memory between two requesters: instruction fetch (I) and data load/store (D).
- All three ports use the same bus protocol: ready/valid/wen/addr/wdata/wmask out, rvalid/rdata back.
- One transaction is outstanding at a time. The arbiter records the owner and routes the one-cycle rvalid pulse back to it.
- Sits between the core's fetch/LSU stages and the memory module.

---
 rtl/membus_arbiter_pkg.sv | 26 ++
 rtl/membus_arbiter_if.sv | 24 ++
 rtl/membus_arbiter_select.sv | 37 +++
 rtl/membus_arbiter.sv | 98 +++++++++
 tb/tb_membus_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/membus_arbiter_pkg.sv
// Shared widths, owner encoding and request bundle for the memory bus arbiter.
package membus_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 16;
  localparam int WMASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    Owner_I = 1'b0,
    Owner_D = 1'b1
  } Owner;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic                   wen;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0]  wdata;
    logic [WMASK_WIDTH-1:0] wmask;
  } membus_req_t;

endpackage

// File: rtl/membus_arbiter_if.sv
// One memory-bus link: command (valid/wen/addr/wdata/wmask) with ready, one-cycle rvalid/rdata back.
interface membus_arbiter_if;
  import membus_pkg::*;

  logic                   ready;
  logic                   valid;
  logic                   wen;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  wdata;
  logic [WMASK_WIDTH-1:0] wmask;
  logic                   rvalid;
  logic [DATA_WIDTH-1:0]  rdata;

  modport master (
    output valid, wen, addr, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, wen, addr, wdata, wmask,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/membus_arbiter_select.sv
// Combinational I/D grant pick; zero latency. Fixed D-over-I by default,
// alternating on contention when MEMBUS_ARBITER_ROUND_ROBIN_EN is defined.
module membus_arb_select
  import membus_pkg::*;
(
  input  logic i_valid,
  input  logic d_valid,
  input  Owner last_grant,
  input  logic enable,
  output logic grant_valid,
  output Owner grant_owner
);

  assign grant_valid = enable && (i_valid || d_valid);

`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    grant_owner = Owner_I;
    if (i_valid && d_valid) begin
      grant_owner = (last_grant == Owner_D) ? Owner_I : Owner_D;
    end else if (d_valid) begin
      grant_owner = Owner_D;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;

  always_comb begin
    grant_owner = Owner_I;
    if (d_valid) begin
      grant_owner = Owner_D;
    end
  end
`endif

endmodule

// File: rtl/membus_arbiter.sv
// Two-requester arbiter onto one single-port memory; one outstanding transaction, no added latency.
// Grants only when the slot is free (idle or response cycle) and mem ready; MEMBUS_ARBITER_ROUND_ROBIN_EN selects alternation.
module membus_arbiter
  import membus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  membus_arbiter_if.slave  i_bus,
  membus_arbiter_if.slave  d_bus,
  membus_arbiter_if.master mem_bus
);

  state_t      r_state;
  Owner        r_owner;
  Owner        r_last_grant;
  state_t      w_state_nxt;
  Owner        w_owner_nxt;
  Owner        w_last_nxt;

  membus_req_t w_i_req;
  membus_req_t w_d_req;
  membus_req_t w_req;
  logic        w_busy;
  logic        w_free;
  logic        w_enable;
  logic        w_grant_valid;
  Owner        w_grant_owner;
  logic        w_accept;

  assign w_i_req = {i_bus.valid, i_bus.wen, i_bus.addr, i_bus.wdata, i_bus.wmask};
  assign w_d_req = {d_bus.valid, d_bus.wen, d_bus.addr, d_bus.wdata, d_bus.wmask};

  // The response cycle releases the slot so a new command can issue alongside it.
  assign w_busy   = (r_state == S_BUSY);
  assign w_free   = !w_busy || mem_bus.rvalid;
  assign w_enable = w_free && mem_bus.ready;

  membus_arb_select u_select (
    .i_valid     (i_bus.valid),
    .d_valid     (d_bus.valid),
    .last_grant  (r_last_grant),
    .enable      (w_enable),
    .grant_valid (w_grant_valid),
    .grant_owner (w_grant_owner)
  );

  always_comb begin
    w_req = '0;
    if (w_grant_valid) begin
      w_req = (w_grant_owner == Owner_D) ? w_d_req : w_i_req;
    end
  end

  assign w_accept = w_req.valid && mem_bus.ready;

  assign mem_bus.valid = w_req.valid;
  assign mem_bus.wen   = w_req.wen;
  assign mem_bus.addr  = w_req.addr;
  assign mem_bus.wdata = w_req.wdata;
  assign mem_bus.wmask = w_req.wmask;

  // Readies reduce to free&&ready / free&&ready&&!d_valid under fixed priority.
  assign d_bus.ready = w_enable &&
                       !(i_bus.valid && d_bus.valid && (w_grant_owner == Owner_I));
  assign i_bus.ready = w_enable &&
                       (!d_bus.valid || (i_bus.valid && (w_grant_owner == Owner_I)));

  assign i_bus.rvalid = mem_bus.rvalid && w_busy && (r_owner == Owner_I);
  assign d_bus.rvalid = mem_bus.rvalid && w_busy && (r_owner == Owner_D);
  assign i_bus.rdata  = mem_bus.rdata;
  assign d_bus.rdata  = mem_bus.rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_grant;
    if (w_accept) begin
      w_state_nxt = S_BUSY;
      w_owner_nxt = w_grant_owner;
      w_last_nxt  = w_grant_owner;
    end else if (mem_bus.rvalid) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= Owner_I;
      r_last_grant <= Owner_I;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter with a small variable-latency memory model behind it.
module tb_membus_arbiter;
  import membus_pkg::*;

`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  membus_arbiter_if i_bus ();
  membus_arbiter_if d_bus ();
  membus_arbiter_if mem_bus ();

  membus_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .i_bus   (i_bus),
    .d_bus   (d_bus),
    .mem_bus (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: response pulse 'lat' cycles after accept; writes commit on the response edge.
  logic [31:0] mem [0:255];
  bit          loaded = 1'b0;
  int          cnt = 0;
  int          lat = 1;
  logic [15:0] p_addr = '0;
  logic        p_wen = 1'b0;
  logic [31:0] p_wdata = '0;
  logic [3:0]  p_wmask = '0;

  assign mem_bus.rvalid = (cnt == 1);
  assign mem_bus.rdata  = (cnt == 1) ? mem[p_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (!loaded) begin
      loaded <= 1'b1;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h00] <= 32'hAAAA0000;
      mem[8'h01] <= 32'hBBBB1111;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'h11223344;
    end else if (cnt == 1 && p_wen) begin
      for (int b = 0; b < 4; b++)
        if (p_wmask[b]) mem[p_addr[7:0]][8*b +: 8] <= p_wdata[8*b +: 8];
    end
    if (cnt > 0) cnt <= cnt - 1;
    if (mem_bus.valid && mem_bus.ready) begin
      cnt     <= lat;
      p_addr  <= mem_bus.addr;
      p_wen   <= mem_bus.wen;
      p_wdata <= mem_bus.wdata;
      p_wmask <= mem_bus.wmask;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b0;
    mem_bus.ready = 1'b1;
    i_bus.valid = 1'b0; i_bus.wen = 1'b0; i_bus.addr = '0; i_bus.wdata = '0; i_bus.wmask = '0;
    d_bus.valid = 1'b0; d_bus.wen = 1'b0; d_bus.addr = '0; d_bus.wdata = '0; d_bus.wmask = '0;

    // Reset state
    cyc();
    chk("rst_i_ready",  i_bus.ready,   1);
    chk("rst_d_ready",  d_bus.ready,   1);
    chk("rst_mem_valid", mem_bus.valid, 0);
    chk("rst_i_rvalid", i_bus.rvalid,  0);
    chk("rst_d_rvalid", d_bus.rvalid,  0);

    // I-only read of 0x0010
    rst = 1'b1;
    i_bus.valid = 1'b1; i_bus.addr = 16'h0010;
    #1;
    chk("t1_mem_valid", mem_bus.valid, 1);
    chk("t1_mem_addr",  mem_bus.addr,  16'h0010);
    chk("t1_i_ready",   i_bus.ready,   1);
    cyc();
    i_bus.valid = 1'b0;
    #1;
    chk("t1_i_rvalid", i_bus.rvalid, 1);
    chk("t1_i_rdata",  i_bus.rdata,  32'hDEADBEEF);
    chk("t1_d_rvalid", d_bus.rvalid, 0);
    cyc();
    #1;
    chk("t1_i_rvalid_off", i_bus.rvalid, 0);

    // I and D together: D write wins, I issues on the D response cycle
    i_bus.valid = 1'b1; i_bus.addr = 16'h0020; i_bus.wen = 1'b0;
    d_bus.valid = 1'b1; d_bus.addr = 16'h0020; d_bus.wen = 1'b1;
    d_bus.wdata = 32'h12345678; d_bus.wmask = 4'b1111;
    #1;
    chk("t2_i_ready",  i_bus.ready,  0);
    chk("t2_d_ready",  d_bus.ready,  1);
    chk("t2_mem_wen",  mem_bus.wen,  1);
    chk("t2_mem_wdata", mem_bus.wdata, 32'h12345678);
    cyc();
    d_bus.valid = 1'b0;
    #1;
    chk("t2_d_rvalid",   d_bus.rvalid,  1);
    chk("t2_i_rvalid",   i_bus.rvalid,  0);
    chk("t2_i_ready",    i_bus.ready,   1);
    chk("t2_mem_valid",  mem_bus.valid, 1);
    chk("t2_mem_wen_rd", mem_bus.wen,   0);
    cyc();
    i_bus.valid = 1'b0;
    #1;
    chk("t2_i_rvalid_rd", i_bus.rvalid, 1);
    chk("t2_i_rdata",     i_bus.rdata,  32'h12345678);
    chk("t2_d_rvalid_rd", d_bus.rvalid, 0);
    cyc();

    // Back-to-back I reads of 0x0000, 0x0001
    i_bus.valid = 1'b1; i_bus.addr = 16'h0000;
    #1;
    chk("t3_mem_addr0", mem_bus.addr, 16'h0000);
    cyc();
    i_bus.addr = 16'h0001;
    #1;
    chk("t3_i_rvalid0", i_bus.rvalid,  1);
    chk("t3_i_rdata0",  i_bus.rdata,   32'hAAAA0000);
    chk("t3_mem_valid1", mem_bus.valid, 1);
    chk("t3_mem_addr1", mem_bus.addr,  16'h0001);
    cyc();
    i_bus.valid = 1'b0;
    #1;
    chk("t3_i_rvalid1", i_bus.rvalid, 1);
    chk("t3_i_rdata1",  i_bus.rdata,  32'hBBBB1111);
    cyc();

    // D partial write with 2-cycle latency while I waits
    lat = 2;
    d_bus.valid = 1'b1; d_bus.wen = 1'b1; d_bus.addr = 16'h0030;
    d_bus.wdata = 32'hCAFEF00D; d_bus.wmask = 4'b0011;
    i_bus.valid = 1'b1; i_bus.addr = 16'h0010; i_bus.wen = 1'b0;
    #1;
    chk("t4_i_ready0", i_bus.ready, 0);
    cyc();
    d_bus.valid = 1'b0;
    #1;
    chk("t4_i_ready1",  i_bus.ready,   0);
    chk("t4_mem_valid", mem_bus.valid, 0);
    chk("t4_i_rvalid1", i_bus.rvalid,  0);
    chk("t4_d_rvalid1", d_bus.rvalid,  0);
    cyc();
    lat = 1;
    #1;
    chk("t4_d_rvalid",   d_bus.rvalid,  1);
    chk("t4_i_rvalid2",  i_bus.rvalid,  0);
    chk("t4_i_ready2",   i_bus.ready,   1);
    chk("t4_mem_addr_i", mem_bus.addr,  16'h0010);
    cyc();
    i_bus.valid = 1'b0;
    #1;
    chk("t4_i_rvalid", i_bus.rvalid, 1);
    chk("t4_i_rdata",  i_bus.rdata,  32'hDEADBEEF);
    cyc();
    d_bus.valid = 1'b1; d_bus.wen = 1'b0; d_bus.addr = 16'h0030;
    cyc();
    d_bus.valid = 1'b0;
    #1;
    chk("t4_d_rdata_mask", d_bus.rdata, 32'h1122F00D);
    cyc();

    // Reset while busy, then the old response arrives
    lat = 2;
    i_bus.valid = 1'b1; i_bus.addr = 16'h0000;
    cyc();
    i_bus.valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_i_ready_busy", i_bus.ready, 0);
    cyc();
    rst = 1'b1;
    lat = 1;
    #1;
    chk("t5_stray_seen", mem_bus.rvalid, 1);
    chk("t5_i_rvalid",   i_bus.rvalid,   0);
    chk("t5_d_rvalid",   d_bus.rvalid,   0);
    chk("t5_i_ready",    i_bus.ready,    1);
    cyc();

    // Memory not ready: nothing granted
    mem_bus.ready = 1'b0;
    i_bus.valid = 1'b1; i_bus.addr = 16'h0040; i_bus.wen = 1'b0;
    d_bus.valid = 1'b1; d_bus.addr = 16'h0050; d_bus.wen = 1'b0;
    #1;
    chk("t6_i_ready",   i_bus.ready,   0);
    chk("t6_d_ready",   d_bus.ready,   0);
    chk("t6_mem_valid", mem_bus.valid, 0);
    cyc();
    #1;
    chk("t6_i_rvalid", i_bus.rvalid, 0);
    chk("t6_d_rvalid", d_bus.rvalid, 0);

    // Contention for four grants
    mem_bus.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic        odd;
      logic [15:0] exp_addr;
      odd      = (k % 2) == 1;
      exp_addr = (RR && odd) ? 16'h0040 : 16'h0050;
      #1;
      chk($sformatf("t7_mem_valid%0d", k), mem_bus.valid, 1);
      chk($sformatf("t7_mem_addr%0d", k),  mem_bus.addr,  exp_addr);
      chk($sformatf("t7_i_ready%0d", k),   i_bus.ready,   RR && odd);
      chk($sformatf("t7_d_ready%0d", k),   d_bus.ready,   !(RR && odd));
      cyc();
    end
    i_bus.valid = 1'b0;
    d_bus.valid = 1'b0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
